// File: rtl/pmod_uart_pkg.sv
// pmod_uart_pkg: shared types and elaboration helpers for the PMOD UART transmitter.
package pmod_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Bit period in clocks, rounded to the nearest integer (halves round up).
  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + (baud / 2)) / baud);
  endfunction

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Read/write pointer width; pointers wrap naturally for power-of-two depths.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pmod_uart_if.sv
// pmod_uart_if: byte-stream handshake into the transmitter FIFO.
interface pmod_uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_tdata;
  logic                 s_tvalid;
  logic                 s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/pmod_uart_fifo.sv
// pmod_uart_fifo: synchronous FIFO with occupancy count; caller guarantees
// no push when full and no pop when empty.
module pmod_uart_fifo
  import pmod_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_rdata,
  output logic [cnt_width(DEPTH)-1:0] o_count
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy tracking; push+pop together leaves the count alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a cleared count makes stale entries unreachable.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/pmod_uart_tx.sv
// pmod_uart_tx: FIFO-buffered UART transmitter (start, DATA_BITS LSB first, stop).
// Build macro EEMBC_POWER_EN adds ts_req / pmod_pin, a fixed-length low
// timestamp pulse on a rising edge of ts_req.
module pmod_uart_tx
  import pmod_uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_CYCLES  = 1000
) (
  input  logic                             sys_clock,
  input  logic                             reset,
  pmod_uart_if.slave                       s_axis,
  output logic                             pmod_uart_txd,
  output logic                             busy,
  output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count
`ifdef EEMBC_POWER_EN
  ,
  input  logic                             ts_req,
  output logic                             pmod_pin
`endif
);
  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $error("pmod_uart_tx: CLK_HZ/BAUD rounds to a bit period below 2 cycles");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_bits
    $error("pmod_uart_tx: DATA_BITS must be 5..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("pmod_uart_tx: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (TS_CYCLES < 1) begin : g_chk_ts
    $error("pmod_uart_tx: TS_CYCLES must be at least 1");
  end

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [DIV_W-1:0]     r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_txd;
  logic                 r_rdy_en;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_txd_nxt;
  logic [DATA_BITS-1:0] w_fifo_rdata;
  logic [CNT_W-1:0]     w_fifo_cnt;

  // r_rdy_en keeps s_tready low through reset and for the cycle it releases.
  assign w_ready         = r_rdy_en && (w_fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign s_axis.s_tready = w_ready;
  assign w_push          = s_axis.s_tvalid && w_ready;
  assign w_tick          = (r_baud_cnt == '0);

  pmod_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .i_clk   (sys_clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_wdata (s_axis.s_tdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_cnt)
  );

  // State register.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, FIFO pop and next line level.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_txd_nxt   = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fifo_cnt != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_txd_nxt = 1'b0;
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_txd_nxt = r_shift[0];
        if (w_tick && (r_bit_cnt == '0)) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Baud down-counter, bit counter, shifter and registered line driver.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_rdy_en   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_txd    <= w_txd_nxt;
      if (w_pop) begin
        r_shift    <= w_fifo_rdata;
        r_baud_cnt <= DIV_LOAD;
      end else if (r_state != ST_IDLE) begin
        if (w_tick) begin
          r_baud_cnt <= DIV_LOAD;
          if (r_state == ST_START) begin
            r_bit_cnt <= BIT_LOAD;
          end else if (r_state == ST_DATA) begin
            r_shift <= r_shift >> 1;
            if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt - 1'b1;
        end
      end
    end
  end

  assign pmod_uart_txd = r_txd;
  assign fifo_count    = w_fifo_cnt;
  assign busy          = (r_state != ST_IDLE) || (w_fifo_cnt != '0);

`ifdef EEMBC_POWER_EN
  localparam int TS_W = (TS_CYCLES > 1) ? $clog2(TS_CYCLES) : 1;

  logic            r_ts_q;
  logic            r_ts_d;
  logic            r_ts_rise;
  logic            r_pin;
  logic [TS_W-1:0] r_ts_cnt;

  // Register ts_req, detect its rising edge, then hold pmod_pin low for
  // TS_CYCLES cycles; a rise seen while the pin is already low is dropped.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_ts_q    <= 1'b0;
      r_ts_d    <= 1'b0;
      r_ts_rise <= 1'b0;
      r_pin     <= 1'b1;
      r_ts_cnt  <= '0;
    end else begin
      r_ts_q    <= ts_req;
      r_ts_d    <= r_ts_q;
      r_ts_rise <= r_ts_q && !r_ts_d;
      if (r_ts_rise && r_pin) begin
        r_pin    <= 1'b0;
        r_ts_cnt <= TS_W'(TS_CYCLES - 1);
      end else if (!r_pin) begin
        if (r_ts_cnt == '0) r_pin    <= 1'b1;
        else                r_ts_cnt <= r_ts_cnt - 1'b1;
      end
    end
  end

  assign pmod_pin = r_pin;
`endif

endmodule

// File: tb/tb_pmod_uart_tx.sv
// tb_pmod_uart_tx: scoreboard bench. DUT A uses default parameters (bit period
// 868 clocks); DUT B uses CLK_HZ=450, BAUD=100 (rounds up to 5 clocks) and
// DATA_BITS=5. A line monitor per DUT decodes frames and checks them against
// the bytes queued at push time.
module tb_pmod_uart_tx;
  import pmod_uart_pkg::*;

  localparam int DIV_A = 868;
  localparam int DIV_B = 5;
  localparam int DB_A  = 8;
  localparam int DB_B  = 5;
  localparam int TS_A  = 1000;

  logic sys_clock = 1'b0;
  logic rst_n     = 1'b0;
  always #5 sys_clock = ~sys_clock;

  pmod_uart_if #(.DATA_BITS(DB_A)) if_a ();
  pmod_uart_if #(.DATA_BITS(DB_B)) if_b ();

  logic       txd_a, txd_b, busy_a, busy_b;
  logic [4:0] cnt_a, cnt_b;
`ifdef EEMBC_POWER_EN
  logic ts_req_a = 1'b0;
  logic ts_req_b = 1'b0;
  logic pin_a, pin_b;
`endif

  pmod_uart_tx #(
    .CLK_HZ(100000000), .BAUD(115200), .DATA_BITS(DB_A), .FIFO_DEPTH(16), .TS_CYCLES(TS_A)
  ) u_dut_a (
    .sys_clock     (sys_clock),
    .reset         (rst_n),
    .s_axis        (if_a),
    .pmod_uart_txd (txd_a),
    .busy          (busy_a),
    .fifo_count    (cnt_a)
`ifdef EEMBC_POWER_EN
    ,
    .ts_req        (ts_req_a),
    .pmod_pin      (pin_a)
`endif
  );

  pmod_uart_tx #(
    .CLK_HZ(450), .BAUD(100), .DATA_BITS(DB_B), .FIFO_DEPTH(16), .TS_CYCLES(20)
  ) u_dut_b (
    .sys_clock     (sys_clock),
    .reset         (rst_n),
    .s_axis        (if_b),
    .pmod_uart_txd (txd_b),
    .busy          (busy_b),
    .fifo_count    (cnt_b)
`ifdef EEMBC_POWER_EN
    ,
    .ts_req        (ts_req_b),
    .pmod_pin      (pin_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic mon_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_txd(input int which);
    return (which == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic [4:0] b_pat(input int i);
    logic [4:0] t;
    t = 5'((i * 11) + 9);
    return (i == 0) ? 5'h1F : t;
  endfunction

  // Decode frames on one line: every bit slot must hold one level for exactly
  // div samples; back-to-back frames must be separated by one idle sample.
  task automatic mon_frames(input int which);
    int         div, nb, n;
    bit         pend, stable, aborted;
    logic       line;
    logic [9:0] lv, exp_lv;
    logic [7:0] exp8;
    div  = (which == 0) ? DIV_A : DIV_B;
    nb   = (which == 0) ? DB_A : DB_B;
    pend = 1'b0;
    forever begin
      if (!pend) begin
        @(negedge sys_clock);
        if (!(mon_on && rst_n && (get_txd(which) === 1'b0))) continue;
      end
      pend    = 1'b0;
      lv      = '0;
      stable  = 1'b1;
      aborted = 1'b0;
      for (int s = 0; s < nb + 2; s++) begin
        for (int c = 0; c < div; c++) begin
          if (s != 0 || c != 0) @(negedge sys_clock);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          line = get_txd(which);
          if (c == 0) lv[s] = line;
          else if (line !== lv[s]) stable = 1'b0;
        end
        if (aborted) break;
      end
      if (aborted) continue;
      if (((which == 0) ? q_a.size() : q_b.size()) == 0) begin
        check_eq("sb_underflow", (which == 0) ? q_a.size() : q_b.size(), 1);
        continue;
      end
      exp8   = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      exp_lv = '0;
      for (int i = 0; i < nb; i++) exp_lv[i+1] = exp8[i];
      exp_lv[nb+1] = 1'b1;
      check_eq((which == 0) ? "frame_a" : "frame_b", {21'd0, stable, lv}, {21'd0, 1'b1, exp_lv});
      if (((which == 0) ? q_a.size() : q_b.size()) != 0) begin
        n = 0;
        forever begin
          @(negedge sys_clock);
          if (!rst_n) break;
          if (get_txd(which) !== 1'b1) break;
          n++;
          if (n > 4 * div) break;
        end
        if (rst_n) begin
          check_eq((which == 0) ? "gap_a" : "gap_b", n, 1);
          pend = (get_txd(which) === 1'b0);
        end
      end
    end
  endtask

  initial mon_frames(0);
  initial mon_frames(1);

  initial begin
    repeat (80000) @(posedge sys_clock);
    $display("FAIL watchdog: cycle budget exhausted before the end of the run");
    $fatal(1, "watchdog expired");
  end

  task automatic push_a(input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge sys_clock);
    while (!if_a.s_tready && guard < 20000) begin
      @(negedge sys_clock);
      guard++;
    end
    if (guard >= 20000) check_eq("push_a_ready_timeout", if_a.s_tready, 1);
    if_a.s_tdata  = d;
    if_a.s_tvalid = 1'b1;
    q_a.push_back(d);
    @(posedge sys_clock);
    #1;
    if_a.s_tvalid = 1'b0;
    if_a.s_tdata  = ~d;
  endtask

  initial begin
    int   b, acc, guard, n_low, n_busy;
    logic rdy;
`ifdef EEMBC_POWER_EN
    int   n_bad;
    logic exp_pin;
`endif
    if_a.s_tvalid = 1'b0;
    if_a.s_tdata  = '0;
    if_b.s_tvalid = 1'b0;
    if_b.s_tdata  = '0;
    repeat (3) @(negedge sys_clock);

    check_eq("rst_txd_a", txd_a, 1);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_count_a", cnt_a, 0);
    check_eq("rst_ready_a", if_a.s_tready, 0);
    check_eq("rst_txd_b", txd_b, 1);
    check_eq("rst_ready_b", if_b.s_tready, 0);
`ifdef EEMBC_POWER_EN
    check_eq("rst_pin_a", pin_a, 1);
`endif

    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", if_a.s_tready, 0);
    @(posedge sys_clock);
    #1;
    check_eq("ready_first_edge_a", if_a.s_tready, 1);
    check_eq("ready_first_edge_b", if_b.s_tready, 1);
    mon_on = 1'b1;

    // 0x55 on DUT A: latency, data capture at push, busy duration.
    @(negedge sys_clock);
    if_a.s_tdata  = 8'h55;
    if_a.s_tvalid = 1'b1;
    q_a.push_back(8'h55);
    @(posedge sys_clock);
    #1;
    if_a.s_tvalid = 1'b0;
    if_a.s_tdata  = 8'hAA;
    check_eq("count_after_push_a", cnt_a, 1);
    check_eq("busy_after_push_a", busy_a, 1);
    check_eq("txd_edge_n_a", txd_a, 1);
    @(posedge sys_clock);
    #1;
    check_eq("txd_edge_n1_a", txd_a, 1);
    @(posedge sys_clock);
    #1;
    check_eq("txd_edge_n2_a", txd_a, 0);
    b = 3;
    while (b < 20000) begin
      @(posedge sys_clock);
      #1;
      if (!busy_a) break;
      b++;
    end
    check_eq("busy_len_a", b, 10 * DIV_A + 1);
    check_eq("txd_idle_after_a", txd_a, 1);
    repeat (3) @(negedge sys_clock);
    check_eq("sb_drain_a", q_a.size(), 0);

`ifdef EEMBC_POWER_EN
    @(negedge sys_clock);
    ts_req_a = 1'b1;
    n_low = 0;
    n_bad = 0;
    for (int k = 0; k <= TS_A + 10; k++) begin
      @(posedge sys_clock);
      #1;
      exp_pin = !(k >= 2 && k <= TS_A + 1);
      if (pin_a == 1'b0) n_low++;
      if (pin_a !== exp_pin) n_bad++;
      if (k == 200) ts_req_a = 1'b0;
      if (k == 499) ts_req_a = 1'b1;
    end
    check_eq("ts_low_cycles", n_low, TS_A);
    check_eq("ts_shape", n_bad, 0);
    ts_req_a = 1'b0;
`endif

    // DUT B: 17 back-to-back pushes with s_tvalid held; the first pop
    // coincides with the second push.
    acc   = 0;
    guard = 0;
    @(negedge sys_clock);
    if_b.s_tvalid = 1'b1;
    if_b.s_tdata  = b_pat(0);
    while (acc < 17 && guard < 200) begin
      rdy = if_b.s_tready;
      @(posedge sys_clock);
      #1;
      if (rdy) begin
        q_b.push_back({3'b000, if_b.s_tdata});
        acc++;
        check_eq("count_b", cnt_b, (acc == 1) ? 1 : acc - 1);
      end
      guard++;
      @(negedge sys_clock);
      if_b.s_tdata = b_pat(acc);
    end
    if (acc != 17) check_eq("accepted_b", acc, 17);
    check_eq("ready_full_b", if_b.s_tready, 0);
    check_eq("count_full_b", cnt_b, 16);
    @(posedge sys_clock);
    #1;
    check_eq("count_hold_b", cnt_b, 16);
    @(negedge sys_clock);
    if_b.s_tvalid = 1'b0;
    guard = 0;
    while ((busy_b || q_b.size() != 0) && guard < 2000) begin
      @(negedge sys_clock);
      guard++;
    end
    repeat (3) @(negedge sys_clock);
    check_eq("sb_drain_b", q_b.size(), 0);
    check_eq("busy_drain_b", busy_b, 0);

    // DUT A: reset in the middle of a frame with more bytes queued.
    push_a(8'h00);
    push_a(8'h3C);
    push_a(8'hC3);
    push_a(8'h81);
    repeat (3000) @(posedge sys_clock);
    #1;
    check_eq("pre_reset_line_a", txd_a, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_txd_a", txd_a, 1);
    check_eq("reset_count_a", cnt_a, 0);
    check_eq("reset_busy_a", busy_a, 0);
    q_a.delete();
    q_b.delete();
    repeat (2) @(negedge sys_clock);
    rst_n = 1'b1;
    n_low  = 0;
    n_busy = 0;
    for (int k = 0; k < 3 * DIV_A; k++) begin
      @(negedge sys_clock);
      if (txd_a == 1'b0) n_low++;
      if (busy_a == 1'b1) n_busy++;
    end
    check_eq("no_partial_frame_a", n_low, 0);
    check_eq("no_busy_after_reset_a", n_busy, 0);
    check_eq("count_after_reset_a", cnt_a, 0);
    check_eq("ready_after_reset_a", if_a.s_tready, 1);
    check_eq("sb_final_a", q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_uart_tx.md
PMOD_UART_TX -- requirements
Module: pmod_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, sys_clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..8, payload bits per frame.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two, minimum 2, transmit FIFO entries.
REQ-005 Parameter TS_CYCLES, default 1000, minimum 1, timestamp pulse length in cycles; used only with EEMBC_POWER_EN.
REQ-006 sys_clock  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 s_tdata  input  DATA_BITS  byte to transmit.
REQ-009 s_tvalid  input  1  s_tdata valid.
REQ-010 s_tready  output  1  FIFO can accept.
REQ-011 pmod_uart_txd  output  1  serial line, idle high.
REQ-012 busy  output  1  frame in progress or FIFO non-empty.
REQ-013 fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 ts_req  input  1  timestamp request; present only with EEMBC_POWER_EN.
REQ-015 pmod_pin  output  1  EEMBC timestamp pin, idle high; present only with EEMBC_POWER_EN.

Function
REQ-016 Bit period DIV SHALL be CLK_HZ/BAUD rounded to nearest integer, computed at elaboration; DIV<2 SHALL fail elaboration.
REQ-017 Push SHALL occur on a cycle with s_tvalid=1 and s_tready=1; s_tready SHALL equal (fifo_count < FIFO_DEPTH) and SHALL NOT depend combinationally on s_tvalid.
REQ-018 FSM states IDLE, START, DATA, STOP; IDLE with fifo_count>0 SHALL pop the head into the shift register and enter START on the next edge.
REQ-019 START drives 0 for DIV cycles; DATA drives DATA_BITS bits LSB first, DIV cycles each; STOP drives 1 for DIV cycles, then IDLE.
REQ-020 STOP->IDLE with FIFO non-empty SHALL pop on the first IDLE cycle: consecutive frames separated by exactly one idle cycle.
REQ-021 Latency: push at edge N into empty FIFO with FSM IDLE -> pmod_uart_txd falls after edge N+2.
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 s_tdata is captured at push; later changes SHALL NOT affect queued data.
REQ-024 busy = (state != IDLE) or (fifo_count != 0), registered-state derived, no glitch path from s_tvalid.

Reset
REQ-025 While reset=0: FSM IDLE, FIFO empty, fifo_count=0, s_tready=0, busy=0, pmod_uart_txd=1, pmod_pin=1, all counters 0.
REQ-026 Reset asserted mid-frame SHALL force pmod_uart_txd high asynchronously and discard the frame and FIFO contents.
REQ-027 s_tready SHALL assert on the first edge after reset deasserts.

Configuration
REQ-028 Macro EEMBC_POWER_EN defined: ts_req and pmod_pin exist; a rising edge of registered ts_req drives pmod_pin low for exactly TS_CYCLES cycles, starting the cycle after detection; requests during an active pulse ignored.
REQ-029 Macro EEMBC_POWER_EN undefined: ts_req, pmod_pin, edge detector and pulse counter absent; UART behaviour identical.

Structure
REQ-030 Shared package pmod_uart_pkg SHALL hold the FSM state enum, the DIV computation function and clog2-based width constants.
REQ-031 FIFO SHALL be a sub-module pmod_uart_fifo (parametrised DEPTH, WIDTH, push/pop/count); FSM and shifter stay in the top.

Verification
REQ-032 Defaults, push 0x55 -> txd 0,1,0,1,0,1,0,1,0,1, each held 868 cycles, frame 8680 cycles, busy falls after.
REQ-033 Push 17 bytes back-to-back, s_tvalid held -> 17 accepted, then s_tready=0 with fifo_count=16; all 17 bytes appear on txd in order.
REQ-034 DATA_BITS=5, push 0x1F -> frame 0,1,1,1,1,1,1 (7 bits); upper s_tdata bits ignored.
REQ-035 Reset pulsed at cycle 3000 of a frame with 4 queued bytes -> txd=1 immediately, fifo_count=0, no partial frame after release.
REQ-036 EEMBC_POWER_EN, TS_CYCLES=1000: ts_req rising at edge N -> pmod_pin low edges N+2..N+1001; second rise at N+500 ignored.
REQ-037 Simultaneous push/pop at fifo_count=1 -> fifo_count stays 1; continuous stream shows one idle cycle between frames.
